// File: rtl/parity_check_stream.sv
// Streaming parity checker with a single result register and valid/ready on both sides.
// Each accepted word yields a registered data-parity flag and a parity-error flag.
// A saturating error counter and a sticky error flag feed status logic.
// Optional feature: define PARCHK_WORDCNT_EN to add a wrapping count of accepted words.
module parity_check_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_even,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky,
`ifdef PARCHK_WORDCNT_EN
  output logic [CNT_W-1:0]  word_cnt,
`endif
  input  logic              clr
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             out_valid_q, out_valid_d;
  logic             out_even_q, out_even_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic             accept;
  logic             data_par;
  logic             word_err;

  // Result register frees up in the same cycle it is consumed.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign data_par = ^in_data;
  assign word_err = ((data_par ^ in_par) != mode);

  // Result register next state: load on accept, otherwise drain on consume.
  always_comb begin
    out_valid_d = out_valid_q;
    out_even_d  = out_even_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_even_d  = ~data_par;
      out_err_d   = word_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Error status next state: clr beats a coincident error word.
  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (clr) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (accept && word_err) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != CntMax) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_even_q   <= 1'b0;
      out_err_q    <= 1'b0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_even_q   <= out_even_d;
      out_err_q    <= out_err_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_even   = out_even_q;
  assign out_err    = out_err_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

`ifdef PARCHK_WORDCNT_EN
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  // Accepted-word counter, wraps; clr takes priority like err_cnt.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (clr) begin
      word_cnt_d = '0;
    end else if (accept) begin
      word_cnt_d = word_cnt_q + 1'b1;
    end
  end

  // Word counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule
